// File: rtl/sort_pkg.sv
// sort_pkg: shared definitions for the param_bubble_sort slice.
//   state_t  : sorter FSM states (IDLE, CMP, DONE)
//   j_w      : bit width of the compare index j (holds 0 .. N-2)
//   pass_w   : bit width of the pass counter (holds 0 .. N-2)
//   cnt_w    : bit width of the optional swap counter (holds 0 .. N(N-1)/2)
`timescale 1ns/1ps
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index range 0..n-2 needs clog2(n-1) bits; never fewer than one bit.
    function automatic int j_w(input int n);
        return (n > 2) ? $clog2(n - 1) : 1;
    endfunction

    function automatic int pass_w(input int n);
        return (n > 2) ? $clog2(n - 1) : 1;
    endfunction

    // Worst-case swap total is the maximum inversion count n(n-1)/2.
    function automatic int cnt_w(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: combinational compare-and-order for one adjacent pair.
//   a, b        : elements at positions j and j+1
//   descending  : 0 = smaller value to the lower position, 1 = larger value
//   lo, hi      : values to write back to positions j and j+1
//   swap        : high when the pair is out of order (strict compare, so
//                 equal elements are never exchanged)
`timescale 1ns/1ps
module sort_cmp_swap #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         descending,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swap
);

    always_comb begin
        swap = descending ? (a < b) : (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/param_bubble_sort.sv
// param_bubble_sort: sequential bubble sorter for N unsigned W-bit elements,
// one adjacent compare per clock, early exit after a swap-free pass.
//   clk, rst    : clock and synchronous active-high reset
//   start       : load request, honoured in IDLE or DONE
//   descending  : order mode, latched at load
//   data_in     : unsorted elements, element i = data_in[i*W +: W]
//   data_out    : live working array, same packing as data_in
//   busy        : high while comparing
//   done        : high once sorted, until the next start or reset
//   swap_count  : swaps performed since load (only with SORT_SWAP_COUNT_EN)
// Optional build macro: SORT_SWAP_COUNT_EN adds the swap_count port and counter.
`timescale 1ns/1ps
module param_bubble_sort
    import sort_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           descending,
    input  logic [N*W-1:0] data_in,
    output logic [N*W-1:0] data_out,
    output logic           busy,
    output logic           done
`ifdef SORT_SWAP_COUNT_EN
    ,
    output logic [cnt_w(N)-1:0] swap_count
`endif
);

    localparam int JW = j_w(N);
    localparam int PW = pass_w(N);
    localparam logic [JW-1:0] J_FIRST_LAST = JW'(N - 2);
    localparam logic [PW-1:0] PASS_LAST    = PW'(N - 2);

    state_t          state;
    logic [W-1:0]    r [N];
    logic [JW-1:0]   j;
    logic [PW-1:0]   pass;
    logic            swapped;
    logic            desc_q;

    logic [W-1:0]    a, b, lo, hi;
    logic            swap;
    logic [JW-1:0]   j_last;
    logic            end_of_pass;
    logic            last_pass;

    // Select the pair r[j], r[j+1] with a decoded mux rather than a
    // variable index, so j+1 never needs a wider index than j.
    always_comb begin
        a = r[0];
        b = r[1];
        for (int i = 0; i < N - 1; i++) begin
            if (j == JW'(i)) begin
                a = r[i];
                b = r[i + 1];
            end
        end
    end

    // Each pass settles one more element at the tail, so the pass shrinks.
    always_comb begin
        j_last      = J_FIRST_LAST - JW'(pass);
        end_of_pass = (j == j_last);
        last_pass   = (pass == PASS_LAST);
    end

    sort_cmp_swap #(.W(W)) u_cmp (
        .a          (a),
        .b          (b),
        .descending (desc_q),
        .lo         (lo),
        .hi         (hi),
        .swap       (swap)
    );

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            data_out[i*W +: W] = r[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            desc_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r[i] <= '0;
            end
`ifdef SORT_SWAP_COUNT_EN
            swap_count <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r[i] <= data_in[i*W +: W];
                        end
                        desc_q  <= descending;
                        j       <= '0;
                        pass    <= '0;
                        swapped <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= CMP;
`ifdef SORT_SWAP_COUNT_EN
                        swap_count <= '0;
`endif
                    end
                end

                CMP: begin
                    // Writing the ordered pair back is harmless when no swap
                    // is needed: lo/hi then equal the original values.
                    for (int i = 0; i < N - 1; i++) begin
                        if (j == JW'(i)) begin
                            r[i]     <= lo;
                            r[i + 1] <= hi;
                        end
                    end
`ifdef SORT_SWAP_COUNT_EN
                    if (swap) begin
                        swap_count <= swap_count + 1'b1;
                    end
`endif
                    if (!end_of_pass) begin
                        j       <= j + 1'b1;
                        swapped <= swapped | swap;
                    end else if (last_pass || !(swapped || swap)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        pass    <= pass + 1'b1;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_bubble_sort.sv
`timescale 1ns/1ps
module tb_param_bubble_sort;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           descending;
    logic [N*W-1:0] data_in;
    logic [N*W-1:0] data_out;
    logic           busy;
    logic           done;
`ifdef SORT_SWAP_COUNT_EN
    logic [CW-1:0]  swap_count;
`endif

    param_bubble_sort #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .descending (descending),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done)
`ifdef SORT_SWAP_COUNT_EN
        ,
        .swap_count (swap_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N*W-1:0] data;
        int             c;
        int             inv;
        int             load_cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    // Reference: inversion count by all-pairs scan; compare count and
    // result by running the textbook early-exit bubble sort on an int array.
    function automatic void model(input logic [N*W-1:0] din, input bit desc,
                                  output logic [N*W-1:0] dout, output int c, output int inv);
        int v[N];
        int t;
        bit sw;
        for (int i = 0; i < N; i++) v[i] = int'(din[i*W +: W]);
        inv = 0;
        for (int i = 0; i < N; i++)
            for (int k = i + 1; k < N; k++)
                if (desc ? (v[i] < v[k]) : (v[i] > v[k])) inv++;
        c = 0;
        for (int p = 0; p < N - 1; p++) begin
            sw = 1'b0;
            for (int k = 0; k < N - 1 - p; k++) begin
                c++;
                if (desc ? (v[k] < v[k+1]) : (v[k] > v[k+1])) begin
                    t = v[k]; v[k] = v[k+1]; v[k+1] = t;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
        end
        dout = '0;
        for (int i = 0; i < N; i++) dout[i*W +: W] = W'(v[i]);
    endfunction

    // Called just after the load edge.
    task automatic push_exp(input logic [N*W-1:0] d, input bit desc);
        exp_t e;
        model(d, desc, e.data, e.c, e.inv);
        e.load_cyc = cyc;
        exp_q.push_back(e);
        chk("busy_after_load", 64'(busy), 64'd1);
        chk("done_after_load", 64'(done), 64'd0);
    endtask

    task automatic issue(input logic [N*W-1:0] d, input bit desc);
        data_in    = d;
        descending = desc;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(d, desc);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (done) return;
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: done still %0b after 100 cycles, expected 1", done);
    endtask

    // Monitor: on every rising done, pop the oldest expectation and compare.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done rose with %0d entries queued, expected >0", exp_q.size());
            end else begin
                e = exp_q.pop_front();
                chk("sorted_data", 64'(data_out), 64'(e.data));
                chk("compare_latency", 64'(cyc - e.load_cyc), 64'(e.c));
                chk("busy_in_done", 64'(busy), 64'd0);
`ifdef SORT_SWAP_COUNT_EN
                chk("swap_count", 64'(swap_count), 64'(e.inv));
`endif
            end
        end
        done_prev <= done;
    end

    logic [N*W-1:0] d1, d2;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        descending = 1'b0;
        data_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        issue(pk(3, 1, 4, 2), 1'b0); wait_done();
        issue(pk(3, 1, 4, 2), 1'b1); wait_done();
        issue(pk(1, 2, 3, 4), 1'b0); wait_done();
        issue(pk(5, 5, 0, 5), 1'b0); wait_done();

        // Reset on the second compare cycle aborts the sort.
        issue(pk(3, 1, 4, 2), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_data_out", 64'(data_out), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        issue(pk(2, 4, 1, 3), 1'b0); wait_done();

        // start/data_in wiggling during CMP is ignored; start then held
        // into DONE reloads the last presented data.
        d1 = pk(7, 2, 9, 0);
        issue(d1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            start      = 1'($urandom_range(0, 1));
            data_in    = N*W'($urandom);
            descending = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        d2         = pk(4, 8, 1, 12);
        data_in    = d2;
        descending = 1'b1;
        start      = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(d2, 1'b1);
        wait_done();

        // Randomized vectors.
        for (int k = 0; k < 30; k++) begin
            issue(N*W'($urandom), 1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_bubble_sort.md
Name: param_bubble_sort

Overview:
- Sequential bubble sorter for N unsigned W-bit elements; generalises the fixed 4×4-bit sorter.
- Adds a run-time ascending/descending mode, a start/busy/done handshake, early exit on a swap-free pass, and live visibility of the working array.
- Sits between board switch/register inputs and the display/LED outputs in the lab datapath.

Parameters:
- N, 4, element count; legal range N >= 2.
- W, 4, element width in bits; unsigned.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled request; honoured only in IDLE or DONE.
- descending  in  1  mode select, sampled at load: 0 = ascending (element 0 smallest), 1 = descending (element 0 largest).
- data_in  in  N*W  unsorted elements; element i = data_in[i*W +: W].
- data_out  out  N*W  registered working array, same packing as data_in.
- busy  out  1  high while sorting.
- done  out  1  high in DONE; holds until the next start or reset.
- swap_count  out  CW  present only with SORT_SWAP_COUNT_EN; CW = clog2(N*(N-1)/2 + 1).

Behaviour:
- Reset: synchronous on rst high at posedge. state=IDLE; data_out=0; busy=0; done=0; swap_count=0; j, pass and swapped flag = 0. Reset mid-sort aborts immediately with no partial result kept.
- IDLE: busy=0, done=0. When start=1 at a posedge:
  - load data_in into the working array and latch the mode;
  - set j=0, pass=0, swapped=0;
  - go to CMP.
- CMP: one compare per cycle on elements j and j+1.
  - Swap condition: ascending swaps if r[j] > r[j+1]; descending swaps if r[j] < r[j+1].
  - Comparisons are strict, so equal elements never swap.
  - Any swap sets swapped.
  - If j < N-2-pass: increment j.
  - Else (end of pass):
    - if pass == N-2, or neither swapped nor the current swap is set: go to DONE;
    - otherwise increment pass, set j=0, clear swapped.
- DONE: busy=0, done=1, data_out holds the sorted array.
  - start=1 at a posedge reloads and re-enters CMP, same as from IDLE; done drops on that same edge.
- start while in CMP is ignored; data_in and descending changes are also ignored after load.
- busy=1 exactly while state==CMP.
- Timing, with start sampled at edge t:
  - load happens at t;
  - compares occupy edges t+1 .. t+C, where C = number of compares executed;
  - done=1 after edge t+C.
  - Worst case C = N(N-1)/2 (6 for N=4). Presorted input gives C = N-1 (3 for N=4).
- data_out updates every cycle from the working array, so intermediate passes are observable.

Optional Feature:
- Macro SORT_SWAP_COUNT_EN.
- Defined: adds the swap_count port.
  - Cleared on load; increments once per performed swap.
  - Frozen in DONE; equals the inversion count of the loaded array.
  - Cannot overflow, since CW is sized for N(N-1)/2.
- Undefined: no swap_count port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package sort_pkg holds:
  - the state enum (IDLE, CMP, DONE);
  - clog2-based width helper functions for the j and pass indices and for CW.
- Sub-module sort_cmp_swap, combinational, parameter W:
  - inputs a, b, descending;
  - outputs lo, hi and swap flag.
  - Instantiated once; it operates on the indexed pair r[j], r[j+1].

Test Plan:
- N=4, W=4, ascending, data_in elements {3,1,4,2} (index 0 first) -> data_out {1,2,3,4}; done rises 6 edges after load (no swap-free pass before the last); swap_count=3.
- Same data, descending=1 -> data_out {4,3,2,1}; swap_count=3.
- Presorted {1,2,3,4}, ascending -> done after 3 compares (early exit), swap_count=0, data_out unchanged.
- Duplicates {5,5,0,5}, ascending -> {0,5,5,5}; equal elements never swap; swap_count=2.
- rst=1 asserted on the 2nd compare cycle -> next edge: state IDLE, data_out=0, busy=0, done=0; a new start then sorts correctly.
- Toggle start and data_in during CMP -> ignored, result matches the originally loaded data. start held in DONE -> reloads with the new data_in, done drops for the duration of the new sort.
